// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the core pipeline controller:
// sequencer states, the canonical nop encoding and the default counter width.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam int          CNT_W_DEF = 16;

    // True when a de source operand is read and names the given register.
    function automatic logic reg_match(input logic       flag,
                                       input logic [4:0] rd_addr,
                                       input logic [4:0] wr_addr);
        return flag && (rd_addr == wr_addr);
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count register with synchronous reset/clear and saturation.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= {W{1'b0}};
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use interlock, memory-wait freeze with timeout,
// redirect/flush on taken jumps, and saturating event counters.
module pipe_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 2,
    parameter int MEM_TO    = 255,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_rd_reg1_flag,
    input  logic [4:0]       de_rd_addr1,
    input  logic             de_rd_reg2_flag,
    input  logic [4:0]       de_rd_addr2,
    input  logic             ex_load,
    input  logic [4:0]       ex_wr_reg_addr,
    input  logic             lsu_req,
    input  logic             lsu_ready,
    input  logic             jump_en,
    input  logic [31:0]      jump_addr,
    output logic             hold_pc,
    output logic             hold_if_de,
    output logic             hold_de_ex,
    output logic             flush_if_de,
    output logic             bubble_ex,
    output logic             redirect_en,
    output logic [31:0]      redirect_addr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_timeout
);

    localparam int WAIT_W = $clog2(MEM_TO + 1);
    localparam int FL_W   = $clog2(FLUSH_CYC + 1);

    state_t              state_r, state_nx;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_nx;
    logic [FL_W-1:0]     flush_cnt_r, flush_cnt_nx;
    logic                pend_r, pend_nx;
    logic [31:0]         pend_addr_r, pend_addr_nx;

    logic                load_use_s;
    logic                mem_hold_s;
    logic                lu_hold_s;
    logic                redir_s;
    logic [31:0]         redir_addr_s;
    logic                flush_s;
    logic                timeout_s;

    assign load_use_s = ex_load && (ex_wr_reg_addr != 5'd0) &&
                        (reg_match(de_rd_reg1_flag, de_rd_addr1, ex_wr_reg_addr) ||
                         reg_match(de_rd_reg2_flag, de_rd_addr2, ex_wr_reg_addr));

    // Next-state and per-cycle control decode; priority is mem wait, redirect, load-use.
    always_comb begin
        state_nx     = state_r;
        wait_cnt_nx  = wait_cnt_r;
        flush_cnt_nx = flush_cnt_r;
        pend_nx      = pend_r;
        pend_addr_nx = pend_addr_r;
        mem_hold_s   = 1'b0;
        lu_hold_s    = 1'b0;
        redir_s      = 1'b0;
        redir_addr_s = jump_addr;
        flush_s      = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            S_RUN: begin
                if (lsu_req && !lsu_ready) begin
                    mem_hold_s  = 1'b1;
                    state_nx    = S_MEM_WAIT;
                    wait_cnt_nx = {WAIT_W{1'b0}};
                    if (jump_en) begin
                        pend_nx      = 1'b1;
                        pend_addr_nx = jump_addr;
                    end else begin
                        pend_nx = 1'b0;
                    end
                end else if (jump_en) begin
                    redir_s      = 1'b1;
                    flush_s      = 1'b1;
                    state_nx     = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
                    flush_cnt_nx = FL_W'(FLUSH_CYC);
                end else if (load_use_s) begin
                    lu_hold_s = 1'b1;
                end else begin
                    state_nx = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_ready || (wait_cnt_r == WAIT_W'(MEM_TO))) begin
                    timeout_s = !lsu_ready;
                    state_nx  = S_RUN;
                    pend_nx   = 1'b0;
                    if (jump_en || pend_r) begin
                        redir_s      = 1'b1;
                        flush_s      = 1'b1;
                        redir_addr_s = jump_en ? jump_addr : pend_addr_r;
                        state_nx     = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
                        flush_cnt_nx = FL_W'(FLUSH_CYC);
                    end else begin
                        redir_s = 1'b0;
                    end
                end else begin
                    mem_hold_s  = 1'b1;
                    wait_cnt_nx = wait_cnt_r + WAIT_W'(1);
                    if (jump_en) begin
                        pend_nx      = 1'b1;
                        pend_addr_nx = jump_addr;
                    end else begin
                        pend_nx = pend_r;
                    end
                end
            end
            S_FLUSH: begin
                // Only the jump itself and bubbles reach lsu here, so lsu_req is not examined.
                flush_s = 1'b1;
                if (jump_en) begin
                    redir_s      = 1'b1;
                    flush_cnt_nx = FL_W'(FLUSH_CYC);
                end else if (flush_cnt_r <= FL_W'(2)) begin
                    state_nx = S_RUN;
                end else begin
                    flush_cnt_nx = flush_cnt_r - FL_W'(1);
                end
            end
            default: begin
                state_nx = S_RUN;
            end
        endcase
    end

    // Sequencer state, wait/flush counters and pending-jump latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_RUN;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            flush_cnt_r <= {FL_W{1'b0}};
            pend_r      <= 1'b0;
            pend_addr_r <= 32'd0;
        end else begin
            state_r     <= state_nx;
            wait_cnt_r  <= wait_cnt_nx;
            flush_cnt_r <= flush_cnt_nx;
            pend_r      <= pend_nx;
            pend_addr_r <= pend_addr_nx;
        end
    end

    assign hold_pc       = mem_hold_s | lu_hold_s;
    assign hold_if_de    = mem_hold_s | lu_hold_s;
    assign hold_de_ex    = mem_hold_s;
    assign flush_if_de   = flush_s;
    assign bubble_ex     = flush_s | lu_hold_s;
    assign redirect_en   = redir_s;
    assign redirect_addr = redir_s ? redir_addr_s : 32'd0;
    assign mem_timeout   = timeout_s;

    sat_cnt #(.W(CNT_W)) u_cnt_stall (
        .clk(clk), .rst(rst), .clear(1'b0), .inc(mem_hold_s | lu_hold_s), .value(cnt_stall)
    );
    sat_cnt #(.W(CNT_W)) u_cnt_flush (
        .clk(clk), .rst(rst), .clear(1'b0), .inc(redir_s), .value(cnt_flush)
    );
    sat_cnt #(.W(CNT_W)) u_cnt_timeout (
        .clk(clk), .rst(rst), .clear(1'b0), .inc(timeout_s), .value(cnt_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a MEM_TO=4 instance for function checks and
// a CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        f1, f2, ex_load, lsu_req, lsu_ready, jump_en;
    logic [4:0]  a1, a2, ex_wr;
    logic [31:0] jump_addr;

    logic        hold_pc, hold_if_de, hold_de_ex, flush_if_de, bubble_ex, redirect_en, mem_timeout;
    logic [31:0] redirect_addr;
    logic [15:0] cnt_stall, cnt_flush, cnt_timeout;

    logic        s_hold_pc, s_hold_if_de, s_hold_de_ex, s_flush_if_de, s_bubble_ex, s_redirect_en, s_mem_timeout;
    logic [31:0] s_redirect_addr;
    logic [1:0]  s_cnt_stall, s_cnt_flush, s_cnt_timeout;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYC(2), .MEM_TO(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .de_rd_reg1_flag(f1), .de_rd_addr1(a1), .de_rd_reg2_flag(f2), .de_rd_addr2(a2),
        .ex_load(ex_load), .ex_wr_reg_addr(ex_wr), .lsu_req(lsu_req), .lsu_ready(lsu_ready),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .hold_pc(hold_pc), .hold_if_de(hold_if_de), .hold_de_ex(hold_de_ex),
        .flush_if_de(flush_if_de), .bubble_ex(bubble_ex), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr), .mem_timeout(mem_timeout),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_timeout(cnt_timeout)
    );

    pipe_ctrl #(.FLUSH_CYC(2), .MEM_TO(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .de_rd_reg1_flag(f1), .de_rd_addr1(a1), .de_rd_reg2_flag(f2), .de_rd_addr2(a2),
        .ex_load(ex_load), .ex_wr_reg_addr(ex_wr), .lsu_req(lsu_req), .lsu_ready(lsu_ready),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .hold_pc(s_hold_pc), .hold_if_de(s_hold_if_de), .hold_de_ex(s_hold_de_ex),
        .flush_if_de(s_flush_if_de), .bubble_ex(s_bubble_ex), .redirect_en(s_redirect_en),
        .redirect_addr(s_redirect_addr), .mem_timeout(s_mem_timeout),
        .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush), .cnt_timeout(s_cnt_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f1 = 1'b0; f2 = 1'b0; a1 = 5'd0; a2 = 5'd0; ex_load = 1'b0; ex_wr = 5'd0;
        lsu_req = 1'b0; lsu_ready = 1'b0; jump_en = 1'b0; jump_addr = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        step();
        rst = 1'b0;
        #1;
        cmp_cnt++;
        if ({hold_pc, hold_if_de, hold_de_ex, flush_if_de, bubble_ex, redirect_en, mem_timeout, redirect_addr} !== 39'd0) begin
            err_cnt++; $display("FAIL reset_outputs: got %0h expected 0",
                {hold_pc, hold_if_de, hold_de_ex, flush_if_de, bubble_ex, redirect_en, mem_timeout, redirect_addr});
        end
        cmp_cnt++;
        if ({cnt_stall, cnt_flush, cnt_timeout} !== 48'd0) begin
            err_cnt++; $display("FAIL reset_counters: got %0h expected 0", {cnt_stall, cnt_flush, cnt_timeout});
        end
    endtask

    task automatic test_load_use();
        ex_load = 1'b1; ex_wr = 5'd5; f1 = 1'b1; a1 = 5'd5;
        #1;
        cmp_cnt++;
        if ({hold_pc, hold_if_de, bubble_ex, hold_de_ex} !== 4'b1110) begin
            err_cnt++; $display("FAIL lu_rs1_hit: got %b expected 1110", {hold_pc, hold_if_de, bubble_ex, hold_de_ex});
        end
        step();
        ex_load = 1'b0;
        #1;
        cmp_cnt++;
        if ({hold_pc, bubble_ex} !== 2'b00) begin
            err_cnt++; $display("FAIL lu_one_cycle: got %b expected 00", {hold_pc, bubble_ex});
        end
        cmp_cnt++;
        if (cnt_stall !== 16'd1) begin
            err_cnt++; $display("FAIL lu_cnt_stall: got %0d expected 1", cnt_stall);
        end
        ex_load = 1'b1; ex_wr = 5'd0; a1 = 5'd0;
        #1;
        cmp_cnt++;
        if ({hold_pc, hold_if_de, bubble_ex} !== 3'b000) begin
            err_cnt++; $display("FAIL lu_x0: got %b expected 000", {hold_pc, hold_if_de, bubble_ex});
        end
        ex_wr = 5'd5; a1 = 5'd5; f1 = 1'b0;
        #1;
        cmp_cnt++;
        if (hold_pc !== 1'b0) begin
            err_cnt++; $display("FAIL lu_flag_off: got %b expected 0", hold_pc);
        end
        ex_wr = 5'd7; f2 = 1'b1; a2 = 5'd7;
        #1;
        cmp_cnt++;
        if ({hold_pc, bubble_ex} !== 2'b11) begin
            err_cnt++; $display("FAIL lu_rs2_hit: got %b expected 11", {hold_pc, bubble_ex});
        end
        step();
        idle();
        #1;
        cmp_cnt++;
        if (cnt_stall !== 16'd2) begin
            err_cnt++; $display("FAIL lu_cnt_stall2: got %0d expected 2", cnt_stall);
        end
    endtask

    task automatic test_mem_wait();
        lsu_req = 1'b1; lsu_ready = 1'b1;
        #1;
        cmp_cnt++;
        if ({hold_pc, hold_if_de, hold_de_ex} !== 3'b000) begin
            err_cnt++; $display("FAIL mem_same_cycle: got %b expected 000", {hold_pc, hold_if_de, hold_de_ex});
        end
        step();
        lsu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp_cnt++;
            if ({hold_pc, hold_if_de, hold_de_ex, bubble_ex} !== 4'b1110) begin
                err_cnt++; $display("FAIL mem_hold_%0d: got %b expected 1110", i, {hold_pc, hold_if_de, hold_de_ex, bubble_ex});
            end
            step();
        end
        lsu_ready = 1'b1;
        #1;
        cmp_cnt++;
        if ({hold_pc, hold_if_de, hold_de_ex} !== 3'b000) begin
            err_cnt++; $display("FAIL mem_ready_drop: got %b expected 000", {hold_pc, hold_if_de, hold_de_ex});
        end
        step();
        idle();
        #1;
        cmp_cnt++;
        if (cnt_stall !== 16'd5) begin
            err_cnt++; $display("FAIL mem_cnt_stall: got %0d expected 5", cnt_stall);
        end
    endtask

    task automatic test_redirect();
        jump_en = 1'b1; jump_addr = 32'h80;
        #1;
        cmp_cnt++;
        if ({redirect_en, flush_if_de, bubble_ex} !== 3'b111 || redirect_addr !== 32'h80) begin
            err_cnt++; $display("FAIL redir_first: got %b addr %0h expected 111 addr 80",
                {redirect_en, flush_if_de, bubble_ex}, redirect_addr);
        end
        step();
        jump_en = 1'b0; jump_addr = 32'd0;
        ex_load = 1'b1; ex_wr = 5'd5; f1 = 1'b1; a1 = 5'd5;
        #1;
        cmp_cnt++;
        if ({redirect_en, flush_if_de, bubble_ex, hold_pc} !== 4'b0110 || redirect_addr !== 32'd0) begin
            err_cnt++; $display("FAIL redir_second: got %b addr %0h expected 0110 addr 0",
                {redirect_en, flush_if_de, bubble_ex, hold_pc}, redirect_addr);
        end
        step();
        idle();
        #1;
        cmp_cnt++;
        if ({flush_if_de, bubble_ex} !== 2'b00) begin
            err_cnt++; $display("FAIL redir_end: got %b expected 00", {flush_if_de, bubble_ex});
        end
        cmp_cnt++;
        if (cnt_flush !== 16'd1 || cnt_stall !== 16'd5) begin
            err_cnt++; $display("FAIL redir_counts: got flush %0d stall %0d expected 1 5", cnt_flush, cnt_stall);
        end
    endtask

    task automatic test_jump_in_wait();
        lsu_req = 1'b1; lsu_ready = 1'b0;
        step();
        jump_en = 1'b1; jump_addr = 32'h100;
        #1;
        cmp_cnt++;
        if ({redirect_en, hold_pc} !== 2'b01) begin
            err_cnt++; $display("FAIL jw_no_redirect: got %b expected 01", {redirect_en, hold_pc});
        end
        step();
        jump_en = 1'b0; jump_addr = 32'd0;
        #1;
        cmp_cnt++;
        if ({redirect_en, hold_pc} !== 2'b01) begin
            err_cnt++; $display("FAIL jw_still_wait: got %b expected 01", {redirect_en, hold_pc});
        end
        step();
        lsu_ready = 1'b1;
        #1;
        cmp_cnt++;
        if ({redirect_en, flush_if_de, bubble_ex, hold_pc} !== 4'b1110 || redirect_addr !== 32'h100) begin
            err_cnt++; $display("FAIL jw_exit_redirect: got %b addr %0h expected 1110 addr 100",
                {redirect_en, flush_if_de, bubble_ex, hold_pc}, redirect_addr);
        end
        step();
        idle();
        #1;
        cmp_cnt++;
        if ({redirect_en, flush_if_de, bubble_ex} !== 3'b011) begin
            err_cnt++; $display("FAIL jw_flush2: got %b expected 011", {redirect_en, flush_if_de, bubble_ex});
        end
        step();
        cmp_cnt++;
        if ({flush_if_de, cnt_flush, cnt_stall} !== {1'b0, 16'd2, 16'd8}) begin
            err_cnt++; $display("FAIL jw_end: got flush %b cnt_flush %0d cnt_stall %0d expected 0 2 8",
                flush_if_de, cnt_flush, cnt_stall);
        end
    endtask

    task automatic test_timeout();
        lsu_req = 1'b1; lsu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            cmp_cnt++;
            if ({hold_pc, hold_de_ex, mem_timeout} !== 3'b110) begin
                err_cnt++; $display("FAIL to_wait_%0d: got %b expected 110", i, {hold_pc, hold_de_ex, mem_timeout});
            end
            step();
        end
        #1;
        cmp_cnt++;
        if ({mem_timeout, hold_pc} !== 2'b10) begin
            err_cnt++; $display("FAIL to_pulse: got %b expected 10", {mem_timeout, hold_pc});
        end
        step();
        idle();
        #1;
        cmp_cnt++;
        if ({mem_timeout, hold_pc} !== 2'b00 || cnt_timeout !== 16'd1 || cnt_stall !== 16'd13) begin
            err_cnt++; $display("FAIL to_after: got %b to %0d stall %0d expected 00 1 13",
                {mem_timeout, hold_pc}, cnt_timeout, cnt_stall);
        end
    endtask

    task automatic test_reset_mid();
        lsu_req = 1'b1; lsu_ready = 1'b0;
        step();
        jump_en = 1'b1; jump_addr = 32'h200;
        step();
        rst = 1'b1; jump_en = 1'b0;
        step();
        rst = 1'b0; idle();
        #1;
        cmp_cnt++;
        if ({hold_pc, hold_if_de, hold_de_ex, redirect_en, cnt_stall, cnt_flush, cnt_timeout} !== 52'd0) begin
            err_cnt++; $display("FAIL rst_mid_wait: got %0h expected 0",
                {hold_pc, hold_if_de, hold_de_ex, redirect_en, cnt_stall, cnt_flush, cnt_timeout});
        end
        lsu_req = 1'b1; lsu_ready = 1'b1;
        #1;
        cmp_cnt++;
        if ({redirect_en, flush_if_de} !== 2'b00) begin
            err_cnt++; $display("FAIL rst_pending_dropped: got %b expected 00", {redirect_en, flush_if_de});
        end
        idle();
        jump_en = 1'b1; jump_addr = 32'h40;
        step();
        rst = 1'b1; jump_en = 1'b0; jump_addr = 32'd0;
        step();
        rst = 1'b0;
        #1;
        cmp_cnt++;
        if ({flush_if_de, bubble_ex, redirect_en, cnt_flush} !== 19'd0) begin
            err_cnt++; $display("FAIL rst_mid_flush: got %0h expected 0", {flush_if_de, bubble_ex, redirect_en, cnt_flush});
        end
    endtask

    task automatic test_saturation();
        ex_load = 1'b1; ex_wr = 5'd9; f1 = 1'b1; a1 = 5'd9;
        for (int i = 0; i < 3; i++) step();
        cmp_cnt++;
        if (s_cnt_stall !== 2'd3) begin
            err_cnt++; $display("FAIL sat_at_max: got %0d expected 3", s_cnt_stall);
        end
        for (int i = 0; i < 2; i++) step();
        idle();
        #1;
        cmp_cnt++;
        if (s_cnt_stall !== 2'd3 || cnt_stall !== 16'd5) begin
            err_cnt++; $display("FAIL sat_hold: got %0d (wide %0d) expected 3 (wide 5)", s_cnt_stall, cnt_stall);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_jump_in_wait();
        test_timeout();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
